// File: rtl/sat_add_seq_pkg.sv
// sat_add_seq_pkg: shared types, constants and saturation helper for the nibble-serial adder
package sat_add_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;
    localparam int NIB_W = 4;
    localparam int MAX_W = 64;
    // Low w bits hold the signed saturation pattern: msb followed by w-1 copies of ~msb
    function automatic logic [MAX_W-1:0] sat_value(input logic msb, input int w);
        return ({MAX_W{~msb}} >> (MAX_W - w + 1)) | (MAX_W'(msb) << (w - 1));
    endfunction
endpackage

// File: rtl/sat_add_seq_slice.sv
// sat_add_slice: combinational 4-bit adder slice exposing carries into and out of its MSB
module sat_add_slice
    import sat_add_seq_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             c3,
    output logic             c4
);
    assign {c3, sum[NIB_W-2:0]} = NIB_W'(x[NIB_W-2:0]) + NIB_W'(y[NIB_W-2:0]) + NIB_W'(cin);
    assign {c4, sum[NIB_W-1]}   = 2'(x[NIB_W-1]) + 2'(y[NIB_W-1]) + 2'(c3);
endmodule

// File: rtl/sat_add_seq.sv
// sat_add_seq: multi-word signed saturating adder built from one shared 4-bit slice, LSB nibble first
module sat_add_seq
    import sat_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     cout,
    output logic                     ovf
);
    localparam int W = NIB_W * NIBBLES;
    localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic carry, ovf_r, cout_r, c3, c4;
    logic [W-1:0] a_r, b_r, res_r, sat;
    logic [NIB_W-1:0] sum;
    sat_add_slice u_slice (
        .x  (a_r[cnt*NIB_W +: NIB_W]),
        .y  (b_r[cnt*NIB_W +: NIB_W]),
        .cin(carry),
        .sum(sum),
        .c3 (c3),
        .c4 (c4)
    );
    assign sat = W'(sat_value(a_r[W-1], W));
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (cnt == LAST ? SAT : RUN) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == SAT;
    // Saturated value is shown during the done cycle, before the register picks it up
    assign result = (done && ovf_r) ? sat : res_r;
    assign cout = cout_r;
    assign ovf = ovf_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                a_r   <= a;
                b_r   <= b;
                carry <= cin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                res_r[cnt*NIB_W +: NIB_W] <= sum;
                carry <= c4;
                if (cnt == LAST) begin
                    ovf_r  <= c3 ^ c4;
                    cout_r <= c4;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == SAT && ovf_r)
                res_r <= sat;
        end
    end
endmodule
